// File: rtl/sa_row_feeder.sv
// sa_row_feeder: west-edge operand transmitter for the systolic array.
// Valid/ready note: there is no back-pressure. start is a one-cycle request
// honoured only in IDLE; rd_data is trusted exactly one cycle after rd_en;
// en_row[r] qualifies lane r of data_out in the same cycle.
module sa_row_feeder #(
    parameter int DW    = 8,
    parameter int ROWS  = 4,
    parameter int AW    = 10,
    parameter int CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW-1:0]        base_addr,
    input  logic [CNT_W-1:0]     kernel_element,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [ROWS*DW-1:0]   rd_data,
    output logic [ROWS*DW-1:0]   data_out,
    output logic [ROWS-1:0]      en_row,
    output logic                 en_synch,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    // DRAIN lasts ROWS+1 cycles: the last row's window closes ROWS+1 cycles
    // after the final read is issued.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  k_q;
    logic [AW-1:0]     base_q;
    logic              vld_q;
    logic [ROWS-1:0]   en_q;
    logic              en_synch_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and read-port / status outputs; abort overrides everything.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (kernel_element == '0) ? DONE : READ;
            end
            READ: begin
                rd_en   = 1'b1;
                rd_addr = base_q + AW'(cnt_q);
                busy    = 1'b1;
                if (cnt_q == k_q - CNT_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Pass parameters are captured on an accepted start; the counter restarts
    // on every state change and walks through READ and DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            k_q    <= '0;
            base_q <= '0;
        end else begin
            if (state_q == IDLE && start && !abort && kernel_element != '0) begin
                k_q    <= kernel_element;
                base_q <= base_addr;
            end
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == READ || state_q == DRAIN)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Valid tag for rd_data, then the per-row enable skew chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            en_q  <= '0;
        end else if (abort) begin
            vld_q <= 1'b0;
            en_q  <= '0;
        end else begin
            vld_q <= rd_en;
            en_q  <= {en_q[ROWS-2:0], vld_q};
        end
    end

    // en_synch holds high except for the single cycle after an abort,
    // which clears PE accumulation state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_synch_q <= 1'b0;
        else        en_synch_q <= !abort;
    end

    assign en_row   = en_q;
    assign en_synch = en_synch_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] pipe [0:r];

        // Lane r skew: one capture stage plus r delay stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) pipe[i] <= '0;
            end else if (abort) begin
                for (int i = 0; i <= r; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= vld_q ? rd_data[r*DW +: DW] : '0;
                for (int i = 1; i <= r; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign data_out[r*DW +: DW] = en_q[r] ? pipe[r] : '0;
    end

endmodule

// File: tb/tb_sa_row_feeder.sv
// Bench for sa_row_feeder: a synchronous buffer model answers reads, a
// cycle-level model predicts control timing, and an expected queue holds
// the operands each row must present, in output order.
module tb_sa_row_feeder;

    localparam int DW    = 8;
    localparam int ROWS  = 4;
    localparam int AW    = 10;
    localparam int CNT_W = 9;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [AW-1:0]       base_addr;
    logic [CNT_W-1:0]    kernel_element;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [ROWS*DW-1:0]  rd_data;
    logic [ROWS*DW-1:0]  data_out;
    logic [ROWS-1:0]     en_row;
    logic                en_synch;
    logic                busy;
    logic                done;

    sa_row_feeder #(.DW(DW), .ROWS(ROWS), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .kernel_element(kernel_element),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_out(data_out), .en_row(en_row), .en_synch(en_synch),
        .busy(busy), .done(done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters / check ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // ---------------- buffer model ----------------
    int buf_mode = 0;

    function automatic logic [DW-1:0] lane_val(input logic [AW-1:0] a, input int r);
        logic [1:0] rb;
        rb = r[1:0];
        if (buf_mode == 0) return a[7:0] + {6'd0, rb};
        return (a[0] ^ rb[0]) ? 8'hFF : 8'h80;
    endfunction

    // Synchronous read: word appears the cycle after rd_en; junk otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int r = 0; r < ROWS; r++) rd_data[r*DW +: DW] <= lane_val(rd_addr, r);
        end else begin
            rd_data <= $urandom;
        end
    end

    // ---------------- reference model state ----------------
    logic [9:0]    exp_q[$];      // {row[1:0], value[7:0]}
    int            s_cyc = -1000;
    int            pk = 0;
    logic [AW-1:0] pbase = '0;
    int            kill_cyc = -1;
    int            synch_low_cyc = -10;
    bit            mon_en = 1'b0;

    function automatic int pass_len(input int k);
        return (k == 0) ? 1 : k + ROWS + 2;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int            m_rel;
    bit            m_act;
    logic [9:0]    m_e;
    logic [ROWS-1:0] m_en;
    logic [AW-1:0] m_addr;

    always @(negedge clk) begin
        if (mon_en) begin
            m_rel = cyc - s_cyc;
            m_act = (m_rel >= 1) && (m_rel <= pass_len(pk)) &&
                    !(kill_cyc >= s_cyc && cyc > kill_cyc);
            for (int r = 0; r < ROWS; r++)
                m_en[r] = m_act && pk > 0 && m_rel >= 3 + r && m_rel <= pk + 2 + r;
            chk("rd_en", rd_en, m_act && pk > 0 && m_rel <= pk);
            if (m_act && pk > 0 && m_rel <= pk) begin
                m_addr = pbase + AW'(m_rel - 1);
                chk("rd_addr", rd_addr, m_addr);
            end
            chk("busy", busy, m_act);
            chk("done", done, m_act && m_rel == pass_len(pk));
            chk("en_row", en_row, m_en);
            chk("en_synch", en_synch, (cyc == synch_low_cyc) ? 0 : 1);
            for (int r = 0; r < ROWS; r++) begin
                if (en_row[r]) begin
                    chk("sb_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        m_e = exp_q.pop_front();
                        chk("sb_row", r, m_e[9:8]);
                        chk("sb_data", data_out[r*DW +: DW], m_e[7:0]);
                    end
                end else begin
                    chk("lane_zero", data_out[r*DW +: DW], 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns one cycle after start.
    task automatic start_pass(input logic [AW-1:0] b, input int k);
        int kk;
        s_cyc = cyc;
        pk    = k;
        pbase = b;
        for (int t = 3; t <= k + ROWS + 1; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                kk = t - 3 - r;
                if (kk >= 0 && kk < k) exp_q.push_back({r[1:0], lane_val(b + AW'(kk), r)});
            end
        end
        base_addr      = b;
        kernel_element = CNT_W'(k);
        start          = 1'b1;
        idle(1);
        start          = 1'b0;
        base_addr      = $urandom;
        kernel_element = CNT_W'($urandom_range(1, 20));
    endtask

    task automatic pulse_abort(input bit with_start);
        abort         = 1'b1;
        start         = with_start;
        kill_cyc      = cyc;
        synch_low_cyc = cyc + 1;
        idle(1);
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_en_row"}, en_row, 0);
        chk({tag, "_en_synch"}, en_synch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // ---------------- main sequence ----------------
    int rk;
    logic [AW-1:0] rb;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; kernel_element = '0;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("synch_pre_edge", en_synch, 0);
        idle(1);
        chk("synch_after_release", en_synch, 1);
        mon_en = 1'b1;
        idle(1);

        // Reference pass: K=9, base 0x010, lane r = n + r.
        buf_mode = 0;
        start_pass(10'h010, 9);
        idle(pass_len(9) + 1);
        chk("sb_drained_ref", exp_q.size(), 0);

        // Address wrap past all-ones.
        start_pass(10'h3FE, 4);
        idle(pass_len(4) + 1);
        chk("sb_drained_wrap", exp_q.size(), 0);

        // Negative operands pass through unmodified.
        buf_mode = 1;
        start_pass(10'h100, 6);
        idle(pass_len(6) + 1);
        chk("sb_drained_neg", exp_q.size(), 0);
        buf_mode = 0;

        // Abort at S+6, new pass starts at S+8.
        start_pass(10'h040, 9);
        idle(5);
        pulse_abort(1'b0);
        idle(1);
        start_pass(10'h080, 9);
        idle(pass_len(9) + 1);
        chk("sb_drained_abort", exp_q.size(), 0);

        // start while busy at S+5 is ignored.
        start_pass(10'h020, 9);
        idle(4);
        base_addr = 10'h300; kernel_element = 9'd2; start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(pass_len(9) - 4);
        chk("sb_drained_busy", exp_q.size(), 0);

        // K=0: done the next cycle, no reads.
        start_pass(10'h055, 0);
        idle(3);

        // abort and start together: abort wins.
        base_addr = 10'h0AA; kernel_element = 9'd5;
        pulse_abort(1'b1);
        idle(4);

        // Random back-to-back passes: each start lands the cycle after done.
        for (int i = 0; i < 4; i++) begin
            buf_mode = $urandom_range(0, 1);
            rb = AW'($urandom_range(0, 1023));
            rk = $urandom_range(1, 20);
            start_pass(rb, rk);
            idle(pass_len(rk));
            chk("sb_drained_rand", exp_q.size(), 0);
        end
        idle(2);

        // Asynchronous reset in the middle of DRAIN.
        buf_mode = 0;
        start_pass(10'h010, 9);
        idle(10);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("synch_mid_pre_edge", en_synch, 0);
        idle(1);
        chk("synch_mid_after", en_synch, 1);
        chk("busy_mid_after", busy, 0);
        chk("rd_en_mid_after", rd_en, 0);
        exp_q.delete();
        s_cyc = -1000;
        pk = 0;
        mon_en = 1'b1;
        idle(3);

        // Clean pass after the reset.
        start_pass(10'h1F0, 5);
        idle(pass_len(5) + 1);
        chk("sb_drained_post_rst", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_row_feeder.md
Name: sa_row_feeder

Overview:
- Operand transmitter at the west edge of the systolic array; one instance drives the activation rows, a second identical instance drives the weight rows.
- On start, reads kernel_element packed words (one DW lane per row) from the local operand buffer.
- Emits each lane to its PE row with a diagonal skew of r cycles for row r, plus per-row enables and the global en_synch, matching the PE accumulation protocol.

Parameters:
DW, 8, operand width per lane (signed)
ROWS, 4, number of PE rows driven (lanes per buffer word)
AW, 10, operand buffer address width
CNT_W, 9, element counter width (holds kernel_element up to 511)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  synchronous abort; highest priority
base_addr  in  AW  first buffer address; latched on start
kernel_element  in  9  elements per pass (K); latched on start
rd_en  out  1  buffer read strobe
rd_addr  out  AW  buffer read address
rd_data  in  ROWS*DW  buffer word; valid exactly 1 cycle after rd_en; lane r = bits [r*DW +: DW]
data_out  out  ROWS*DW  skewed operands to PE rows; lane r feeds row r in_data/in_weight
en_row  out  ROWS  per-row en_PE
en_synch  out  1  global PE synch
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: rd_en=0, rd_addr=0, data_out=0, en_row=0, en_synch=0, busy=0, done=0. All skew registers clear. FSM enters IDLE.
- en_synch goes to 1 on the first clock edge after reset release. It drops to 0 for exactly one cycle after an abort, which clears all PE psum/cnt state. Otherwise it stays 1.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 and K>0 at cycle S latches base_addr and K, then moves to READ.
- IDLE, K=0: start at S skips READ and DRAIN; done pulses at S+1 and no reads are issued.
- READ: rd_en=1 and rd_addr=base+cnt for cnt=0..K-1, covering cycles S+1..S+K. Address arithmetic is modulo 2^AW (wraps past all-ones). After cnt=K-1, moves to DRAIN.
- Valid pipeline: rd_en is delayed 1 cycle to tag rd_data, giving a valid lane at S+2..S+K+1.
- Row 0 output register: captures lane 0 and presents it at S+3..S+K+2.
- Row r: lane r passes through r extra registers and is presented at S+3+r..S+K+2+r. en_row[r] is high exactly over that window.
- Lane zeroing: whenever en_row[r]=0, lane r of data_out is 0.
- DRAIN: waits until the last row's window ends, then moves to DONE.
- DONE: one cycle with done=1, then IDLE. done falls at S+K+ROWS+2. For K=9, ROWS=4, done is at S+15.
- busy: 1 from S+1 through the done cycle inclusive.
- start while busy: ignored, with no effect on the latched K or base.
- abort (any state, including mid-READ/DRAIN): next edge forces IDLE; rd_en=0, en_row=0, data_out=0, busy=0, skew pipes cleared, en_synch=0 for one cycle; no done pulse.
- abort and start in the same cycle: abort wins and start is dropped.
- Back-to-back: start is accepted again in the cycle after done (idle cycle), giving a new pass without overlap.
- Values pass through unmodified (signed, no saturation). The block performs no arithmetic on data.

Test Plan:
- ROWS=4, K=9, base=0x010, buffer word n holds lanes {n+3,n+2,n+1,n} (lane0=n) → rd_addr 0x010..0x018 at S+1..S+9; lane r = 0x10+r+k at S+3+r+k, k=0..8; en_row[r] high 9 cycles from S+3+r; done at S+15; busy S+1..S+15.
- base=0x3FE, K=4, AW=10 → rd_addr sequence 0x3FE,0x3FF,0x000,0x001; output lanes in the same order.
- Negative data: lane values 0x80 and 0xFF → data_out lanes carry 0x80/0xFF unchanged; lanes read 0 outside their en_row windows.
- abort at S+6 during K=9 pass → from S+7: rd_en=0, en_row=0, data_out=0, busy=0, en_synch=0 for exactly S+7, back to 1 at S+8; no done; new start at S+8 runs a full clean pass.
- start at S+5 while busy, and K=0 start in IDLE → busy start ignored, original pass timing unchanged; K=0 gives done at S+1, no rd_en.
- rst_n asserted mid-DRAIN, asynchronously → all outputs 0 immediately including en_synch; en_synch=1 one edge after release; FSM in IDLE.
